shift_reg_bank: RTL and testbench

SHIFT_REG_BANK -- requirements
Module: shift_reg_bank

---
 rtl/upscaler_pkg.sv | 23 ++
 rtl/shift_stage.sv | 55 +++++
 rtl/shift_reg_bank.sv | 104 ++++++++++
 tb/tb_shift_reg_bank.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/upscaler_pkg.sv
//------------------------------------------------------------------------------
// upscaler_pkg : shared constants and types for the upscaler line datapath
// Revision     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package upscaler_pkg;

  typedef enum logic [1:0] {
    MODE_SHIFT   = 2'b00,
    MODE_ROTATE  = 2'b01,
    MODE_HOLD    = 2'b10,
    MODE_REVERSE = 2'b11
  } mode_e;

  // True for the modes that push a new word in and therefore grow the fill count
  function automatic logic mode_fills(input logic [1:0] m);
    return (m == MODE_SHIFT) || (m == MODE_REVERSE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/shift_stage.sv
//------------------------------------------------------------------------------
// shift_stage : one multi-channel register stage with its next-value selector
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module shift_stage
  import upscaler_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] from_prev,
  input  logic [WIDTH-1:0] from_next,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_d;

  always_comb begin
    w_d = r_q;
    if (clr) begin
      w_d = '0;
    end else if (load) begin
      w_d = load_val;
    end else if (en) begin
      case (mode)
        MODE_SHIFT,
        MODE_ROTATE:  w_d = from_prev;
        MODE_REVERSE: w_d = from_next;
        default:      w_d = r_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else begin
      r_q <= w_d;
    end
  end

  assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/shift_reg_bank.sv
//------------------------------------------------------------------------------
// shift_reg_bank : DEPTH-stage multi-channel shift/rotate/reverse register bank
// Revision       : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module shift_reg_bank
  import upscaler_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int CHANNELS = 3,
  parameter int DEPTH    = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               en,
  input  logic                               clr,
  input  logic                               load,
  input  logic [1:0]                         mode,
  input  logic [CHANNELS*DATA_W-1:0]         din,
  input  logic [DEPTH*CHANNELS*DATA_W-1:0]   load_data,
  output logic [DEPTH*CHANNELS*DATA_W-1:0]   taps,
  output logic [CHANNELS*DATA_W-1:0]         dout,
  output logic [$clog2(DEPTH+1)-1:0]         fill_cnt,
  output logic                               full
);

  localparam int c_WORD_W = CHANNELS * DATA_W;
  localparam int c_CNT_W  = $clog2(DEPTH + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEPTH);

  logic [c_WORD_W-1:0] w_q [DEPTH];

  generate
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      logic [c_WORD_W-1:0] w_from_prev;
      logic [c_WORD_W-1:0] w_from_next;

      // Stage 0 is fed by din when shifting and by the last stage when rotating
      if (k == 0) begin : g_head
        assign w_from_prev = (mode == MODE_ROTATE) ? w_q[DEPTH-1] : din;
      end else begin : g_body_prev
        assign w_from_prev = w_q[k-1];
      end

      if (k == DEPTH - 1) begin : g_tail
        assign w_from_next = din;
      end else begin : g_body_next
        assign w_from_next = w_q[k+1];
      end

      shift_stage #(
        .WIDTH (c_WORD_W)
      ) u_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .load      (load),
        .en        (en),
        .mode      (mode),
        .from_prev (w_from_prev),
        .from_next (w_from_next),
        .load_val  (load_data[k*c_WORD_W +: c_WORD_W]),
        .q         (w_q[k])
      );

      assign taps[k*c_WORD_W +: c_WORD_W] = w_q[k];
    end
  endgenerate

  assign dout = w_q[DEPTH-1];

  logic [c_CNT_W-1:0] r_fill_cnt;
  logic               r_full;
  logic [c_CNT_W-1:0] w_cnt_nxt;

  always_comb begin
    w_cnt_nxt = r_fill_cnt;
    if (clr) begin
      w_cnt_nxt = '0;
    end else if (load) begin
      w_cnt_nxt = c_CNT_MAX;
    end else if (en && mode_fills(mode) && (r_fill_cnt != c_CNT_MAX)) begin
      w_cnt_nxt = r_fill_cnt + 1'b1;
    end
  end

  // full is registered from the next count so it stays a pure flop output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fill_cnt <= '0;
      r_full     <= 1'b0;
    end else begin
      r_fill_cnt <= w_cnt_nxt;
      r_full     <= (w_cnt_nxt == c_CNT_MAX);
    end
  end

  assign fill_cnt = r_fill_cnt;
  assign full     = r_full;

endmodule

`default_nettype wire

// File: tb/tb_shift_reg_bank.sv
//------------------------------------------------------------------------------
// tb_shift_reg_bank : directed self-checking bench with a per-cycle array model
// Revision          : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_shift_reg_bank;

  localparam int DATA_W   = 8;
  localparam int CHANNELS = 3;
  localparam int DEPTH    = 4;
  localparam int CW       = CHANNELS * DATA_W;
  localparam int TW       = DEPTH * CW;
  localparam int NW       = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          clr = 1'b0;
  logic          load = 1'b0;
  logic [1:0]    mode = 2'b10;
  logic [CW-1:0] din = '0;
  logic [TW-1:0] load_data = '0;
  logic [TW-1:0] taps;
  logic [CW-1:0] dout;
  logic [NW-1:0] fill_cnt;
  logic          full;

  int errs   = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  shift_reg_bank #(
    .DATA_W   (DATA_W),
    .CHANNELS (CHANNELS),
    .DEPTH    (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .clr       (clr),
    .load      (load),
    .mode      (mode),
    .din       (din),
    .load_data (load_data),
    .taps      (taps),
    .dout      (dout),
    .fill_cnt  (fill_cnt),
    .full      (full)
  );

  always #5 clk = ~clk;

  // Behavioural model: a plain array of stage words and an integer fill count
  logic [CW-1:0] m_st [DEPTH];
  int            m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) m_st[k] <= '0;
      m_cnt <= 0;
    end else if (clr) begin
      for (int k = 0; k < DEPTH; k++) m_st[k] <= '0;
      m_cnt <= 0;
    end else if (load) begin
      for (int k = 0; k < DEPTH; k++) m_st[k] <= load_data[k*CW +: CW];
      m_cnt <= DEPTH;
    end else if (en) begin
      case (mode)
        2'b00: begin
          m_st[0] <= din;
          for (int k = 1; k < DEPTH; k++) m_st[k] <= m_st[k-1];
          m_cnt <= (m_cnt + 1 > DEPTH) ? DEPTH : m_cnt + 1;
        end
        2'b01: begin
          m_st[0] <= m_st[DEPTH-1];
          for (int k = 1; k < DEPTH; k++) m_st[k] <= m_st[k-1];
        end
        2'b11: begin
          m_st[DEPTH-1] <= din;
          for (int k = 0; k < DEPTH - 1; k++) m_st[k] <= m_st[k+1];
          m_cnt <= (m_cnt + 1 > DEPTH) ? DEPTH : m_cnt + 1;
        end
        default: ;
      endcase
    end
  end

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (rst_n && en) assert (!$isunknown(mode)) else $error("mode unknown with en high");
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < DEPTH; k++)
        check($sformatf("model_stage%0d", k), 128'(taps[k*CW +: CW]), 128'(m_st[k]));
      check("model_dout", 128'(dout), 128'(m_st[DEPTH-1]));
      check("model_fill", 128'(fill_cnt), 128'(m_cnt));
      check("model_full", 128'(full), 128'(m_cnt == DEPTH));
    end
  end

  task automatic step(input logic c, input logic l, input logic e,
                      input logic [1:0] m, input logic [CW-1:0] d);
    @(negedge clk);
    #1;
    clr = c; load = l; en = e; mode = m; din = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12 rst_n = 1'b1;
    chk_en = 1'b1;

    // Load a non-zero image, then hit async reset with no clock edge
    load_data = {24'h444444, 24'h333333, 24'h222222, 24'h111111};
    step(0, 1, 0, 2'b10, '0);
    step(0, 0, 0, 2'b10, '0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_taps", 128'(taps), 128'(0));
    check("async_rst_fill", 128'(fill_cnt), 128'(0));
    check("async_rst_full", 128'(full), 128'(0));
    @(negedge clk); #2 rst_n = 1'b1;

    // Four shifts fill the bank, a fifth drops the oldest word
    step(0, 0, 1, 2'b00, 24'h010203);
    step(0, 0, 1, 2'b00, 24'h040506);
    step(0, 0, 1, 2'b00, 24'h070809);
    step(0, 0, 1, 2'b00, 24'h0A0B0C);
    check("shift4_dout", 128'(dout), 128'h010203);
    check("shift4_fill", 128'(fill_cnt), 128'd4);
    check("shift4_full", 128'(full), 128'd1);
    step(0, 0, 1, 2'b00, 24'h0D0E0F);
    check("shift5_dout", 128'(dout), 128'h040506);
    check("shift5_fill", 128'(fill_cnt), 128'd4);

    // Load then rotate a full circle
    step(0, 1, 1, 2'b01, 24'hFFFFFF);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 2'b01, 24'h123456);
      check("rotate_fill", 128'(fill_cnt), 128'd4);
    end
    check("rotate_image", 128'(taps), 128'({24'h444444, 24'h333333, 24'h222222, 24'h111111}));

    // clr beats load and en
    step(1, 1, 1, 2'b00, 24'h777777);
    check("clr_prio_taps", 128'(taps), 128'(0));
    check("clr_prio_fill", 128'(fill_cnt), 128'd0);

    // Reverse from cleared, then hold via en low
    step(0, 0, 1, 2'b11, 24'hAABBCC);
    check("rev_taps", 128'(taps), 128'({24'hAABBCC, 72'h0}));
    check("rev_fill", 128'(fill_cnt), 128'd1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 2'b00, 24'h555555);
    check("rev_hold_taps", 128'(taps), 128'({24'hAABBCC, 72'h0}));
    check("rev_hold_fill", 128'(fill_cnt), 128'd1);

    // HOLD mode with en high, then reverse to saturation
    step(0, 0, 1, 2'b10, 24'h999999);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 2'b11, CW'(24'h100000 + i));
    check("rev_sat_fill", 128'(fill_cnt), 128'd4);

    // Reset pulse between edges during a shift run
    step(0, 0, 1, 2'b00, 24'h0F0F0F);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_taps", 128'(taps), 128'(0));
    check("mid_rst_fill", 128'(fill_cnt), 128'd0);
    #1 rst_n = 1'b1;
    din = 24'h2A2B2C;
    @(posedge clk); #1;
    check("post_rst_stage0", 128'(taps[CW-1:0]), 128'h2A2B2C);
    check("post_rst_fill", 128'(fill_cnt), 128'd1);

    step(0, 0, 1, 2'b01, '0);
    step(0, 0, 0, 2'b00, '0);
    @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no end expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
